// File: rtl/lif_timestep_scheduler.sv
// Time-multiplexed leaky integrate-and-fire scheduler.
// One shared LIF datapath visits neurons 0..N_NEURONS-1, one per clock,
// each time a timestep is requested. Potentials live in a register file.
module lif_timestep_scheduler #(
   parameter int N_NEURONS       = 8,
   parameter int POTENTIAL_WIDTH = 16,
   parameter int FRACTION_BITS   = 8
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          step_start,
   input  logic [N_NEURONS-1:0]          spike_in,
   input  logic                          cfg_we,
   input  logic [FRACTION_BITS-1:0]      cfg_lambda,
   input  logic [POTENTIAL_WIDTH-1:0]    cfg_theta,
   input  logic [POTENTIAL_WIDTH-1:0]    cfg_reset_val,
   input  logic                          clear_pot,
   input  logic [$clog2(N_NEURONS)-1:0]  rd_idx,
   output logic [POTENTIAL_WIDTH-1:0]    rd_potential,
   output logic [N_NEURONS-1:0]          spike_out,
   output logic                          busy,
   output logic                          step_done,
   output logic [15:0]                   step_count,
   output logic                          overrun
);

   localparam int IDX_W  = $clog2(N_NEURONS);
   localparam int PROD_W = POTENTIAL_WIDTH + FRACTION_BITS;
   localparam logic [IDX_W-1:0]           LAST_IDX = IDX_W'(N_NEURONS - 1);
   // 1.0 in the fixed-point potential format: the injected current of one input spike
   localparam logic [POTENTIAL_WIDTH-1:0] ONE_FIX  = POTENTIAL_WIDTH'(1) << FRACTION_BITS;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_UPDATE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // Leak: full-width product then drop the fraction bits; the upper bits of the
   // shifted product fit POTENTIAL_WIDTH exactly because lambda < 1.0.
   function automatic logic [POTENTIAL_WIDTH-1:0] leak_mul(
      input logic [POTENTIAL_WIDTH-1:0] pot,
      input logic [FRACTION_BITS-1:0]   lambda
   );
      logic [PROD_W-1:0] prod;
      prod     = {{FRACTION_BITS{1'b0}}, pot} * {{POTENTIAL_WIDTH{1'b0}}, lambda};
      leak_mul = prod[PROD_W-1:FRACTION_BITS];
   endfunction

   // Unsigned add clamped to the all-ones potential instead of wrapping.
   function automatic logic [POTENTIAL_WIDTH-1:0] sat_add(
      input logic [POTENTIAL_WIDTH-1:0] a,
      input logic [POTENTIAL_WIDTH-1:0] b
   );
      logic [POTENTIAL_WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s[POTENTIAL_WIDTH]) begin
         sat_add = {POTENTIAL_WIDTH{1'b1}};
      end else begin
         sat_add = s[POTENTIAL_WIDTH-1:0];
      end
   endfunction

   state_t                     state_q, state_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic [N_NEURONS-1:0]       in_q, in_d;
   logic [POTENTIAL_WIDTH-1:0] pot_q [N_NEURONS];
   logic [POTENTIAL_WIDTH-1:0] pot_d [N_NEURONS];
   logic [N_NEURONS-1:0]       stage_q, stage_d;
   logic [N_NEURONS-1:0]       spike_out_q, spike_out_d;
   logic                       step_done_q, step_done_d;
   logic [15:0]                count_q, count_d;
   logic                       overrun_q, overrun_d;
   logic [FRACTION_BITS-1:0]   lambda_q, lambda_d;
   logic [POTENTIAL_WIDTH-1:0] theta_q, theta_d;
   logic [POTENTIAL_WIDTH-1:0] reset_val_q, reset_val_d;

   logic [POTENTIAL_WIDTH-1:0] pot_cur_s;
   logic                       in_cur_s;
   logic [POTENTIAL_WIDTH-1:0] sum_s;
   logic                       fire_s;
   logic [POTENTIAL_WIDTH-1:0] new_pot_s;
   logic [POTENTIAL_WIDTH-1:0] rd_pot_s;

   // Operand select for the shared datapath: AND-OR mux over the neuron file
   always_comb begin
      pot_cur_s = '0;
      in_cur_s  = 1'b0;
      for (int k = 0; k < N_NEURONS; k++) begin
         pot_cur_s = pot_cur_s | (pot_q[k] & {POTENTIAL_WIDTH{idx_q == IDX_W'(k)}});
         in_cur_s  = in_cur_s  | (in_q[k] & (idx_q == IDX_W'(k)));
      end
   end

   // Shared LIF datapath: leak, integrate, threshold, reset-on-fire
   always_comb begin
      sum_s  = sat_add(leak_mul(pot_cur_s, lambda_q), in_cur_s ? ONE_FIX : {POTENTIAL_WIDTH{1'b0}});
      fire_s = (sum_s >= theta_q);
      if (fire_s) begin
         new_pot_s = reset_val_q;
      end else begin
         new_pot_s = sum_s;
      end
   end

   // Readback mux; an index past the last neuron reads as zero
   always_comb begin
      rd_pot_s = '0;
      for (int k = 0; k < N_NEURONS; k++) begin
         rd_pot_s = rd_pot_s | (pot_q[k] & {POTENTIAL_WIDTH{rd_idx == IDX_W'(k)}});
      end
   end

   // Next-state and datapath write-back for the IDLE/UPDATE/DONE sequencer
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      in_d        = in_q;
      pot_d       = pot_q;
      stage_d     = stage_q;
      spike_out_d = spike_out_q;
      step_done_d = 1'b0;
      count_d     = count_q;
      overrun_d   = overrun_q;
      lambda_d    = lambda_q;
      theta_d     = theta_q;
      reset_val_d = reset_val_q;

      case (state_q)
         ST_IDLE: begin
            // config and clear land on the same edge a step starts, so the
            // step sees the new config and starts from zeroed potentials
            if (cfg_we) begin
               lambda_d    = cfg_lambda;
               theta_d     = cfg_theta;
               reset_val_d = cfg_reset_val;
            end else begin
               lambda_d    = lambda_q;
               theta_d     = theta_q;
               reset_val_d = reset_val_q;
            end
            if (clear_pot) begin
               for (int k = 0; k < N_NEURONS; k++) begin
                  pot_d[k] = '0;
               end
            end else begin
               pot_d = pot_q;
            end
            if (step_start) begin
               in_d    = spike_in;
               idx_d   = '0;
               stage_d = '0;
               state_d = ST_UPDATE;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_UPDATE: begin
            if (step_start) begin
               overrun_d = 1'b1;
            end else begin
               overrun_d = overrun_q;
            end
            for (int k = 0; k < N_NEURONS; k++) begin
               if (idx_q == IDX_W'(k)) begin
                  pot_d[k]   = new_pot_s;
                  stage_d[k] = fire_s;
               end else begin
                  pot_d[k]   = pot_q[k];
                  stage_d[k] = stage_q[k];
               end
            end
            if (idx_q == LAST_IDX) begin
               idx_d       = '0;
               step_done_d = 1'b1;
               state_d     = ST_DONE;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = ST_UPDATE;
            end
         end

         ST_DONE: begin
            if (step_start) begin
               overrun_d = 1'b1;
            end else begin
               overrun_d = overrun_q;
            end
            spike_out_d = stage_q;
            count_d     = count_q + 16'd1;
            state_d     = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and storage registers; reset aborts any step in flight
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         in_q        <= '0;
         for (int k = 0; k < N_NEURONS; k++) begin
            pot_q[k] <= '0;
         end
         stage_q     <= '0;
         spike_out_q <= '0;
         step_done_q <= 1'b0;
         count_q     <= 16'd0;
         overrun_q   <= 1'b0;
         lambda_q    <= '0;
         theta_q     <= '0;
         reset_val_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         in_q        <= in_d;
         pot_q       <= pot_d;
         stage_q     <= stage_d;
         spike_out_q <= spike_out_d;
         step_done_q <= step_done_d;
         count_q     <= count_d;
         overrun_q   <= overrun_d;
         lambda_q    <= lambda_d;
         theta_q     <= theta_d;
         reset_val_q <= reset_val_d;
      end
   end

   assign rd_potential = rd_pot_s;
   assign spike_out    = spike_out_q;
   assign busy         = (state_q != ST_IDLE);
   assign step_done    = step_done_q;
   assign step_count   = count_q;
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_lif_timestep_scheduler.sv
// Bench for lif_timestep_scheduler with four neurons: a small reference model
// predicts each step, expectations are queued at stimulus and popped at step end.
module tb_lif_timestep_scheduler;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        step_start;
   logic [3:0]  spike_in;
   logic        cfg_we;
   logic [7:0]  cfg_lambda;
   logic [15:0] cfg_theta;
   logic [15:0] cfg_reset_val;
   logic        clear_pot;
   logic [1:0]  rd_idx;
   logic [15:0] rd_potential;
   logic [3:0]  spike_out;
   logic        busy;
   logic        step_done;
   logic [15:0] step_count;
   logic        overrun;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   int         m_pot [4];
   int         m_lambda, m_theta, m_rv, m_count;
   logic [3:0] m_last;

   // scoreboard
   logic [3:0] q_spike [$];
   int         q_count [$];
   int         q_pot   [$];

   always #5 clk = ~clk;

   lif_timestep_scheduler #(
      .N_NEURONS(4), .POTENTIAL_WIDTH(16), .FRACTION_BITS(8)
   ) dut (
      .clk(clk), .reset_n(reset_n), .step_start(step_start), .spike_in(spike_in),
      .cfg_we(cfg_we), .cfg_lambda(cfg_lambda), .cfg_theta(cfg_theta),
      .cfg_reset_val(cfg_reset_val), .clear_pot(clear_pot), .rd_idx(rd_idx),
      .rd_potential(rd_potential), .spike_out(spike_out), .busy(busy),
      .step_done(step_done), .step_count(step_count), .overrun(overrun)
   );

   task automatic model_reset();
      for (int k = 0; k < 4; k++) m_pot[k] = 0;
      m_lambda = 0; m_theta = 0; m_rv = 0; m_count = 0; m_last = 4'b0000;
   endtask

   task automatic model_step(input logic [3:0] vin);
      logic [3:0] s;
      int leak, sum;
      s = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         leak = (m_pot[k] * m_lambda) / 256;
         sum  = leak + (vin[k] ? 256 : 0);
         if (sum > 65535) sum = 65535;
         if (sum >= m_theta) begin
            s[k] = 1'b1;
            m_pot[k] = m_rv;
         end else begin
            m_pot[k] = sum;
         end
         q_pot.push_back(m_pot[k]);
      end
      m_count = (m_count + 1) % 65536;
      q_spike.push_back(s);
      q_count.push_back(m_count);
   endtask

   // One full timestep with optional same-cycle clear/config and optional
   // config write attempted while busy (which must be ignored).
   task automatic run_step(input logic [3:0] vin, input bit clr, input bit cfg,
                           input int lam, input int th, input int rv, input bit busy_cfg);
      logic [3:0] exp_s;
      int exp_c, exp_p, lat;
      if (clr) for (int k = 0; k < 4; k++) m_pot[k] = 0;
      if (cfg) begin m_lambda = lam; m_theta = th; m_rv = rv; end
      model_step(vin);
      @(negedge clk);
      step_start = 1'b1; spike_in = vin; clear_pot = clr; cfg_we = cfg;
      cfg_lambda = 8'(lam); cfg_theta = 16'(th); cfg_reset_val = 16'(rv);
      @(negedge clk);
      step_start = 1'b0; clear_pot = 1'b0; spike_in = ~vin;
      if (busy_cfg) begin
         cfg_we = 1'b1; cfg_lambda = 8'd255; cfg_theta = 16'd0; cfg_reset_val = 16'd77;
      end else begin
         cfg_we = 1'b0;
      end
      n_checks++;
      if (busy !== 1'b1) $display("FAIL busy_during_step: got %b want 1", busy); else n_pass++;
      lat = 1;
      while (step_done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         cfg_we = 1'b0;
         lat++;
      end
      n_checks++;
      if (lat !== 5) $display("FAIL step_latency: got %0d cycles want 5", lat); else n_pass++;
      n_checks++;
      if (spike_out !== m_last) $display("FAIL spike_out_stable: got %h want %h", spike_out, m_last);
      else n_pass++;
      @(negedge clk);
      exp_s = q_spike.pop_front();
      exp_c = q_count.pop_front();
      n_checks++;
      if (spike_out !== exp_s) $display("FAIL spike_out: got %h want %h", spike_out, exp_s); else n_pass++;
      n_checks++;
      if (step_count !== 16'(exp_c)) $display("FAIL step_count: got %0d want %0d", step_count, exp_c);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL busy_after_step: got %b want 0", busy); else n_pass++;
      for (int k = 0; k < 4; k++) begin
         rd_idx = 2'(k);
         #1;
         exp_p = q_pot.pop_front();
         n_checks++;
         if (rd_potential !== 16'(exp_p))
            $display("FAIL potential[%0d]: got %0d want %0d", k, rd_potential, exp_p);
         else n_pass++;
      end
      m_last = exp_s;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      model_reset();
      n_checks++;
      if ({spike_out, busy, step_done, overrun} !== 7'd0 || step_count !== 16'd0)
         $display("FAIL reset_outputs: got so=%h busy=%b done=%b cnt=%0d ovr=%b want all 0",
                  spike_out, busy, step_done, step_count, overrun);
      else n_pass++;
      for (int k = 0; k < 4; k++) begin
         rd_idx = 2'(k);
         #1;
         n_checks++;
         if (rd_potential !== 16'd0) $display("FAIL reset_pot[%0d]: got %0d want 0", k, rd_potential);
         else n_pass++;
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_leak_integrate();
      int tbl [10] = '{256, 384, 448, 480, 496, 504, 508, 510, 511, 511};
      for (int i = 0; i < 10; i++) begin
         run_step(4'hF, i == 0, i == 0, 128, 512, 0, 1'b0);
         @(negedge clk);
         rd_idx = 2'd0;
         #1;
         n_checks++;
         if (rd_potential !== 16'(tbl[i]) || spike_out !== 4'h0)
            $display("FAIL leak_table[%0d]: got P=%0d so=%h want P=%0d so=0", i, rd_potential, spike_out, tbl[i]);
         else n_pass++;
      end
   endtask

   task automatic test_spike_reset();
      int   tbl [4] = '{256, 25, 278, 25};
      logic sb  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         run_step(4'h1, i == 0, i == 0, 230, 384, 25, 1'b0);
         @(negedge clk);
         rd_idx = 2'd0;
         #1;
         n_checks++;
         if (rd_potential !== 16'(tbl[i]) || spike_out !== {3'b000, sb[i]})
            $display("FAIL fire_table[%0d]: got P=%0d so=%h want P=%0d so=%h",
                     i, rd_potential, spike_out, tbl[i], {3'b000, sb[i]});
         else n_pass++;
      end
   endtask

   task automatic test_decay();
      int tbl [4] = '{256, 204, 162, 129};
      for (int i = 0; i < 4; i++) begin
         run_step((i == 0) ? 4'h2 : 4'h0, i == 0, i == 0, 204, 16'hFFFF, 0, 1'b0);
         @(negedge clk);
         rd_idx = 2'd1;
         #1;
         n_checks++;
         if (rd_potential !== 16'(tbl[i]))
            $display("FAIL decay_table[%0d]: got %0d want %0d", i, rd_potential, tbl[i]);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] pats [6] = '{4'hF, 4'h5, 4'hA, 4'h3, 4'h0, 4'hC};
      for (int i = 0; i < 6; i++) begin
         run_step(pats[i], i == 0, i == 0, 204, 128, 0, 1'b0);
         n_checks++;
         if (spike_out !== pats[i]) $display("FAIL always_fire[%0d]: got %h want %h", i, spike_out, pats[i]);
         else n_pass++;
      end
   endtask

   task automatic test_cfg_busy_and_clear();
      // theta=512 stays in force although a write of theta=0 is attempted mid-step
      run_step(4'hF, 1'b1, 1'b1, 128, 512, 0, 1'b1);
      run_step(4'hF, 1'b0, 1'b0, 0, 0, 0, 1'b0);
      // clear coincident with start: input neurons begin from zero
      run_step(4'hA, 1'b1, 1'b0, 0, 0, 0, 1'b0);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         rd_idx = 2'(k);
         #1;
         n_checks++;
         if (rd_potential !== ((k % 2 == 1) ? 16'd256 : 16'd0))
            $display("FAIL clear_with_start[%0d]: got %0d want %0d", k, rd_potential, (k % 2 == 1) ? 256 : 0);
         else n_pass++;
      end
   endtask

   task automatic test_overrun_and_abort();
      logic [3:0] exp_s;
      int exp_c, dones;
      run_step(4'h0, 1'b1, 1'b1, 204, 128, 0, 1'b0);
      n_checks++;
      if (overrun !== 1'b0) $display("FAIL overrun_idle: got %b want 0", overrun); else n_pass++;
      model_step(4'h5);
      @(negedge clk); step_start = 1'b1; spike_in = 4'h5;
      @(negedge clk); step_start = 1'b0;
      @(negedge clk); step_start = 1'b1;
      @(negedge clk); step_start = 1'b0;
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         if (step_done === 1'b1) dones++;
         @(negedge clk);
      end
      exp_s = q_spike.pop_front();
      exp_c = q_count.pop_front();
      for (int k = 0; k < 4; k++) void'(q_pot.pop_front());
      m_last = exp_s;
      n_checks++;
      if (dones !== 1) $display("FAIL overrun_done_count: got %0d want 1", dones); else n_pass++;
      n_checks++;
      if (overrun !== 1'b1) $display("FAIL overrun_set: got %b want 1", overrun); else n_pass++;
      n_checks++;
      if (spike_out !== exp_s || step_count !== 16'(exp_c))
         $display("FAIL overrun_step: got so=%h cnt=%0d want so=%h cnt=%0d", spike_out, step_count, exp_s, exp_c);
      else n_pass++;
      run_step(4'h3, 1'b0, 1'b0, 0, 0, 0, 1'b0);
      n_checks++;
      if (overrun !== 1'b1) $display("FAIL overrun_sticky: got %b want 1", overrun); else n_pass++;
      // reset in the middle of UPDATE
      @(negedge clk); step_start = 1'b1; spike_in = 4'hF;
      @(negedge clk); step_start = 1'b0;
      @(negedge clk); reset_n = 1'b0;
      #1;
      model_reset();
      n_checks++;
      if ({spike_out, busy, step_done, overrun} !== 7'd0 || step_count !== 16'd0)
         $display("FAIL abort_outputs: got so=%h busy=%b done=%b cnt=%0d ovr=%b want all 0",
                  spike_out, busy, step_done, step_count, overrun);
      else n_pass++;
      @(negedge clk); reset_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 10; i++) begin
         if (step_done === 1'b1) dones++;
         @(negedge clk);
      end
      n_checks++;
      if (dones !== 0 || spike_out !== 4'h0)
         $display("FAIL abort_no_done: got dones=%0d so=%h want 0 and 0", dones, spike_out);
      else n_pass++;
      run_step(4'hF, 1'b0, 1'b1, 204, 512, 0, 1'b0);
      @(negedge clk);
      rd_idx = 2'd0;
      #1;
      n_checks++;
      if (rd_potential !== 16'd256) $display("FAIL after_abort_pot: got %0d want 256", rd_potential);
      else n_pass++;
   endtask

   initial begin
      reset_n = 1'b0; step_start = 1'b0; spike_in = 4'h0; cfg_we = 1'b0;
      cfg_lambda = 8'd0; cfg_theta = 16'd0; cfg_reset_val = 16'd0;
      clear_pot = 1'b0; rd_idx = 2'd0;
      test_reset();
      test_leak_integrate();
      test_spike_reset();
      test_decay();
      test_back_to_back();
      test_cfg_busy_and_clear();
      test_overrun_and_abort();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: run did not complete within time limit, passed %0d of %0d", n_pass, n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule
